// File: rtl/lockstep_checker.sv
// Lockstep comparator for two cores' bus-side outputs. It raises a one-cycle error pulse
// on divergence and masks further detection until resume plus a blanking window.
module lockstep_checker #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  check_en_i,
  input  logic                  a_instr_req_i,
  input  logic                  b_instr_req_i,
  input  logic [DATA_WIDTH-1:0] a_instr_addr_i,
  input  logic [DATA_WIDTH-1:0] b_instr_addr_i,
  input  logic                  a_data_req_i,
  input  logic                  b_data_req_i,
  input  logic                  a_data_we_i,
  input  logic                  b_data_we_i,
  input  logic [BE_WIDTH-1:0]   a_data_be_i,
  input  logic [BE_WIDTH-1:0]   b_data_be_i,
  input  logic [DATA_WIDTH-1:0] a_data_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_wdata_i,
  input  logic [DATA_WIDTH-1:0] b_data_wdata_i,
  input  logic                  resume_i,
  output logic                  error_o,
  output logic [2:0]            mismatch_vec_o,
  output logic [CNT_WIDTH-1:0]  error_count_o,
  output logic                  masked_o
);

  localparam int unsigned BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    MONITOR    = 2'd0,
    FLAGGED    = 2'd1,
    RECOVERING = 2'd2,
    BLANK      = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic                 error_d;
  logic [2:0]           vec_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 inst_mm, ctrl_mm, wdata_mm, any_mm;

  // Divergence terms; write data is only meaningful on enabled bytes of a write.
  always_comb begin
    inst_mm  = (a_instr_req_i != b_instr_req_i) |
               (a_instr_req_i & (a_instr_addr_i != b_instr_addr_i));
    ctrl_mm  = (a_data_req_i != b_data_req_i) |
               (a_data_req_i & ((a_data_we_i != b_data_we_i) |
                                (a_data_be_i != b_data_be_i) |
                                (a_data_addr_i != b_data_addr_i)));
    wdata_mm = 1'b0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      wdata_mm = wdata_mm |
                 (a_data_be_i[i] & (a_data_wdata_i[8*i +: 8] != b_data_wdata_i[8*i +: 8]));
    end
    wdata_mm = wdata_mm & a_data_req_i & a_data_we_i;
    any_mm   = check_en_i & (inst_mm | ctrl_mm | wdata_mm);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    error_d = 1'b0;
    vec_d   = mismatch_vec_o;
    cnt_d   = error_count_o;
    case (state_q)
      MONITOR: begin
        if (any_mm) begin
          error_d = 1'b1;
          vec_d   = {wdata_mm, ctrl_mm, inst_mm};
          if (error_count_o != '1) cnt_d = error_count_o + CNT_WIDTH'(1);
          state_d = FLAGGED;
        end
      end
      FLAGGED: state_d = RECOVERING;
      RECOVERING: begin
        if (resume_i) begin
          if (BLANK_CYCLES == 0) begin
            state_d = MONITOR;
          end else begin
            blank_d = BLANK_W'(BLANK_LOAD);
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (blank_q == '0) state_d = MONITOR;
        else               blank_d = blank_q - BLANK_W'(1);
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= MONITOR;
      blank_q        <= '0;
      error_o        <= 1'b0;
      mismatch_vec_o <= '0;
      error_count_o  <= '0;
      masked_o       <= 1'b0;
    end else begin
      state_q        <= state_d;
      blank_q        <= blank_d;
      error_o        <= error_d;
      mismatch_vec_o <= vec_d;
      error_count_o  <= cnt_d;
      masked_o       <= (state_d != MONITOR);
    end
  end

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Upstream error detector for the fault-tolerance controller; drives that controller's error input.
- Compares the bus-side outputs of two lockstep cores (A, B) every cycle.
- On divergence, raises a single-cycle error pulse and captures which signal group diverged.
- Masks further detection until the controller signals resume, plus a configurable blanking window.

Parameters:
- DATA_WIDTH, 32, width of instruction/data address and write-data buses.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- BLANK_CYCLES, 4, cycles comparison stays masked after resume_i; 0 means none.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- check_en_i  in  1  1 enables comparison; 0 suppresses new detections.
- a_instr_req_i / b_instr_req_i  in  1  core A/B instruction request.
- a_instr_addr_i / b_instr_addr_i  in  DATA_WIDTH  core A/B instruction address.
- a_data_req_i / b_data_req_i  in  1  core A/B data request.
- a_data_we_i / b_data_we_i  in  1  core A/B data write enable.
- a_data_be_i / b_data_be_i  in  BE_WIDTH  core A/B byte enables.
- a_data_addr_i / b_data_addr_i  in  DATA_WIDTH  core A/B data address.
- a_data_wdata_i / b_data_wdata_i  in  DATA_WIDTH  core A/B write data.
- resume_i  in  1  recovery complete, from controller resume output.
- error_o  out  1  one-cycle error pulse to controller.
- mismatch_vec_o  out  3  captured groups: bit0 instr, bit1 data ctrl/addr, bit2 wdata.
- error_count_o  out  CNT_WIDTH  saturating count of flagged errors.
- masked_o  out  1  1 while detection is masked (any state but MONITOR).

Behaviour:
- Reset (rst_ni=0 at an edge): state=MONITOR; error_o=0; mismatch_vec_o=0; error_count_o=0; masked_o=0; blank counter=0. Reset overrides all events, including mid-recovery.
- Combinational mismatch terms:
  - inst_mm = (a_instr_req != b_instr_req) | (a_instr_req & (a_instr_addr != b_instr_addr)).
  - ctrl_mm = (a_data_req != b_data_req) | (a_data_req & ((we differ) | (be differ) | (data_addr differ))).
  - wdata_mm = a_data_req & a_data_we & (byte-wise OR over i of a_be[i] & (a_wdata byte i != b_wdata byte i)). Disabled bytes are ignored; wdata is compared only when req & we.
  - any_mm = check_en_i & (inst_mm | ctrl_mm | wdata_mm).
- States:
  - MONITOR: if any_mm, then next cycle error_o=1, mismatch_vec_o={wdata_mm,ctrl_mm,inst_mm}, error_count_o += 1 (saturates at all-ones), go to FLAGGED. Latency is 1 cycle from the sampling edge to error_o high. Otherwise stay.
  - FLAGGED: error_o<=0 (pulse width exactly 1); go to RECOVERING. resume_i is ignored here.
  - RECOVERING: mismatches ignored; mismatch_vec_o held. On resume_i=1: if BLANK_CYCLES=0 go to MONITOR, else load blank counter with BLANK_CYCLES-1 and go to BLANK.
  - BLANK: mismatches ignored; decrement the counter; go to MONITOR when the counter reaches 0 (exactly BLANK_CYCLES cycles in BLANK). resume_i is ignored.
- masked_o=1 in FLAGGED, RECOVERING and BLANK; it is registered together with the state.
- mismatch_vec_o changes only on a new flag; it is not cleared on resume.
- check_en_i=0 only blocks new detections; it does not alter recovery progress.
- error_o is never high for two consecutive cycles. No re-flag is possible before resume_i plus the blanking window.

Test Plan:
- Identical A/B traffic for 1000 random cycles, check_en_i=1 -> error_o never 1; error_count_o=0; masked_o=0.
- At cycle 10, b_instr_addr=0x104 vs a=0x100, both req=1 -> error_o=1 only in cycle 11; mismatch_vec_o=3'b001; error_count_o=1; masked_o=1 from cycle 11.
- Write with be=4'b0011, wdata differing only in byte 3 -> no error. Then differing in byte 0 -> mismatch_vec_o=3'b100.
- After a flag, hold mismatch and pulse resume_i at cycle 20, BLANK_CYCLES=4 -> masked_o=0 from cycle 25. The persistent mismatch re-flags with error_o high in cycle 26; error_count_o=2.
- Force 300 flags with CNT_WIDTH=8 -> error_count_o saturates at 255.
- rst_ni=0 for one cycle while in RECOVERING with count=3 -> all outputs 0, state MONITOR, and a mismatch is detected on the next cycle.
